// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_loader
//  Purpose  : Instruction memory of 2^P words with a registered fetch port for
//             the controller, plus a byte-serial program loader. The loader
//             takes a framed byte stream (count byte, then each word as a
//             high byte and a low byte) and writes words from address 0. The
//             CPU is held for the whole load.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    M                   register address width; W = 4 + 2*M
//    P                   instruction address width (1..8), depth = 2^P
//  Ports
//    clk                 in   1   system clock, rising edge
//    rst_n               in   1   asynchronous reset, active low
//    en_read_instr       in   1   fetch request
//    read_address_instr  in   P   fetch address
//    instruction_out     out  W   fetched instruction (registered)
//    load_start          in   1   pulse: begin a program load
//    load_byte           in   8   loader data byte
//    load_valid          in   1   load_byte is valid
//    load_ready          out  1   loader accepts a byte this cycle
//    cpu_hold            out  1   controller must stay idle
//    load_done           out  1   pulse: load finished (ok or error)
//    load_error          out  1   sticky error, cleared by next load_start
//  Build option
//    CHECKSUM_EN         append an XOR checksum byte to every frame
// ============================================================================
module instr_mem_loader #(
   parameter int M = 4,
   parameter int P = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_read_instr,
   input  logic [P-1:0]         read_address_instr,
   output logic [4+2*M-1:0]     instruction_out,
   input  logic                 load_start,
   input  logic [7:0]           load_byte,
   input  logic                 load_valid,
   output logic                 load_ready,
   output logic                 cpu_hold,
   output logic                 load_done,
   output logic                 load_error
);

   localparam int         W       = 4 + 2*M;
   localparam logic [8:0] c_depth = 9'(1 << P);

   typedef enum logic [2:0] {
      ST_RUN  = 3'd0,
      ST_CNT  = 3'd1,
      ST_HI   = 3'd2,
      ST_LO   = 3'd3,
      ST_CHK  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [P:0]     r_ptr;          // one extra bit so a full 2^P frame ends cleanly
   logic [7:0]     r_last;         // index of the final word (count - 1)
   logic [W-9:0]   r_hi;           // upper word bits captured from the high byte
   logic [W-1:0]   r_mem [0:(1<<P)-1];

   logic           w_xfer;
   logic [8:0]     w_count_n;
   logic           w_count_bad;
   logic           w_ptr_last;

   assign w_xfer      = load_valid & load_ready;
   // A count byte of zero stands for 256 words.
   assign w_count_n   = (load_byte == 8'd0) ? 9'd256 : {1'b0, load_byte};
   assign w_count_bad = (w_count_n > c_depth);
   assign w_ptr_last  = (9'(r_ptr) == {1'b0, r_last});

`ifdef CHECKSUM_EN
   logic [7:0]     r_csum;
   logic           w_csum_bad;
   assign w_csum_bad = (load_byte != r_csum);
`endif

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:  if (load_start) w_state_nxt = ST_CNT;
         ST_CNT:  if (w_xfer) w_state_nxt = w_count_bad ? ST_DONE : ST_HI;
         ST_HI:   if (w_xfer) w_state_nxt = ST_LO;
         ST_LO: begin
            if (w_xfer) begin
               if (w_ptr_last) begin
`ifdef CHECKSUM_EN
                  w_state_nxt = ST_CHK;
`else
                  w_state_nxt = ST_DONE;
`endif
               end else begin
                  w_state_nxt = ST_HI;
               end
            end
         end
         ST_CHK:  if (w_xfer) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // FSM state, registered outputs and frame bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_RUN;
         instruction_out <= '0;
         load_ready      <= 1'b0;
         cpu_hold        <= 1'b0;
         load_done       <= 1'b0;
         load_error      <= 1'b0;
         r_ptr           <= '0;
         r_last          <= '0;
         r_hi            <= '0;
`ifdef CHECKSUM_EN
         r_csum          <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         load_ready <= (w_state_nxt == ST_CNT) || (w_state_nxt == ST_HI) ||
                       (w_state_nxt == ST_LO)  || (w_state_nxt == ST_CHK);
         cpu_hold   <= (w_state_nxt != ST_RUN);
         load_done  <= (w_state_nxt == ST_DONE);

         case (r_state)
            ST_RUN: begin
               // A read issued alongside load_start is still serviced;
               // otherwise entering the hold presents a NOP.
               if (en_read_instr)
                  instruction_out <= r_mem[read_address_instr];
               else if (load_start)
                  instruction_out <= '0;
               if (load_start)
                  load_error <= 1'b0;
            end
            ST_CNT: begin
               instruction_out <= '0;
               if (w_xfer) begin
                  r_ptr  <= '0;
                  r_last <= 8'(load_byte - 8'd1);
`ifdef CHECKSUM_EN
                  r_csum <= load_byte;
`endif
                  if (w_count_bad)
                     load_error <= 1'b1;
               end
            end
            ST_HI: begin
               instruction_out <= '0;
               if (w_xfer) begin
                  r_hi <= load_byte[W-9:0];
`ifdef CHECKSUM_EN
                  r_csum <= r_csum ^ load_byte;
`endif
               end
            end
            ST_LO: begin
               instruction_out <= '0;
               if (w_xfer) begin
                  r_ptr <= r_ptr + {{P{1'b0}}, 1'b1};
`ifdef CHECKSUM_EN
                  r_csum <= r_csum ^ load_byte;
`endif
               end
            end
            ST_CHK: begin
               instruction_out <= '0;
`ifdef CHECKSUM_EN
               // Words stay written even when the checksum disagrees.
               if (w_xfer && w_csum_bad)
                  load_error <= 1'b1;
`endif
            end
            default: begin
               instruction_out <= '0;
            end
         endcase
      end
   end

   // Memory array is deliberately not reset so a program survives rst_n.
   always_ff @(posedge clk) begin
      if ((r_state == ST_LO) && w_xfer)
         r_mem[r_ptr[P-1:0]] <= {r_hi, load_byte};
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_mem_loader
//  Purpose  : Self-checking bench for instr_mem_loader. Expected fetch data
//             and load outcomes are queued when stimulus is issued and a
//             monitor pops them when the DUT presents a result.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

   localparam int M     = 4;
   localparam int P     = 6;
   localparam int W     = 4 + 2*M;
   localparam int DEPTH = 1 << P;
`ifdef CHECKSUM_EN
   localparam bit CS_ON = 1'b1;
`else
   localparam bit CS_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en_read_instr = 1'b0;
   logic [P-1:0]  read_address_instr = '0;
   logic [W-1:0]  instruction_out;
   logic          load_start = 1'b0;
   logic [7:0]    load_byte = '0;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic          cpu_hold;
   logic          load_done;
   logic          load_error;

   instr_mem_loader #(.M(M), .P(P)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .en_read_instr      (en_read_instr),
      .read_address_instr (read_address_instr),
      .instruction_out    (instruction_out),
      .load_start         (load_start),
      .load_byte          (load_byte),
      .load_valid         (load_valid),
      .load_ready         (load_ready),
      .cpu_hold           (cpu_hold),
      .load_done          (load_done),
      .load_error         (load_error)
   );

   always #5 clk = ~clk;

   int            n_cmp  = 0;
   int            n_fail = 0;
   logic [W-1:0]  ref_mem [DEPTH];
   bit            ref_vld [DEPTH];
   logic [W-1:0]  fetch_q [$];
   bit            done_q  [$];
   logic [W-1:0]  wq      [$];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm, input string msg);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: %s", nm, msg);
   endtask

   // Monitor: fetch results, NOP during hold, load outcomes
   initial begin
      bit pend;
      forever begin
         @(posedge clk);
         pend = rst_n && en_read_instr && !cpu_hold;
         #1;
         if (pend) begin
            if (fetch_q.size() == 0) fail_now("fetch_extra", "read serviced with nothing expected");
            else chk("fetch_data", instruction_out, fetch_q.pop_front());
         end else if (cpu_hold) begin
            chk("hold_nop", instruction_out, 0);
         end
         if (load_done) begin
            if (done_q.size() == 0) fail_now("done_extra", "load_done with no load expected");
            else chk("done_error", load_error, done_q.pop_front());
         end
      end
   end

   task automatic fill_words(input int n);
      wq.delete();
      repeat (n) wq.push_back(W'($urandom));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit dup);
      int t;
      load_valid = 1'b1;
      load_byte  = b;
      if (dup) load_start = 1'b1;
      t = 0;
      while (1) begin
         @(posedge clk);
         if (load_ready) break;
         t++;
         if (t > 50) begin
            fail_now("byte_timeout", "load_ready never rose");
            break;
         end
      end
      @(negedge clk);
      load_valid = 1'b0;
      load_start = 1'b0;
   endtask

   task automatic fetch(input int a);
      @(negedge clk);
      en_read_instr      = 1'b1;
      read_address_instr = P'(a);
      fetch_q.push_back(ref_mem[a]);
      @(negedge clk);
      en_read_instr = 1'b0;
   endtask

   // pace: 0 back-to-back, 1 valid toggling plus a 10-cycle mid gap, 2 random
   task automatic do_load(input int c, input bit garb, input bit bad, input int pace,
                          input bit rd, input int ra, input bit dup);
      int n, t, idle;
      bit cerr;
      logic [7:0] bq [$];
      logic [7:0] cs, hi, lo;
      n    = (c == 0) ? 256 : c;
      cerr = (n > DEPTH);
      bq.push_back(8'(c));
      cs = 8'(c);
      if (!cerr) begin
         for (int i = 0; i < n; i++) begin
            hi = {(garb ? 4'($urandom) : 4'h0), wq[i][W-1:8]};
            lo = wq[i][7:0];
            bq.push_back(hi);
            bq.push_back(lo);
            cs = cs ^ hi ^ lo;
         end
         if (CS_ON) bq.push_back(cs ^ (bad ? 8'h5A : 8'h00));
      end
      @(negedge clk);
      load_start = 1'b1;
      if (rd) begin
         en_read_instr      = 1'b1;
         read_address_instr = P'(ra);
         fetch_q.push_back(ref_mem[ra]);
      end
      @(negedge clk);
      load_start    = 1'b0;
      en_read_instr = 1'b0;
      chk("hold_after_start", cpu_hold, 1);
      chk("error_cleared", load_error, 0);
      chk("ready_after_start", load_ready, 1);
      if (!cerr) begin
         for (int i = 0; i < n; i++) begin
            ref_mem[i] = wq[i];
            ref_vld[i] = 1'b1;
         end
      end
      done_q.push_back(cerr || (CS_ON && bad));
      for (int k = 0; k < bq.size(); k++) begin
         idle = 0;
         if (pace == 1) begin
            if (k > 0) idle = 1;
            if (k == bq.size() / 2) idle += 10;
         end else if (pace == 2) begin
            idle = $urandom_range(0, 2);
         end
         if (idle > 0) begin
            repeat (idle) @(negedge clk);
            chk("ready_in_gap", load_ready, 1);
         end
         send_byte(bq[k], dup && (k == 3));
         if (k != bq.size() - 1) chk("ready_mid_load", load_ready, 1);
      end
      t = 0;
      while (done_q.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (done_q.size() != 0) begin
         fail_now("done_missing", "no load_done pulse");
         done_q.delete();
      end
      t = 0;
      while (cpu_hold && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("hold_released", cpu_hold, 0);
      wq.delete();
   endtask

   initial begin
      logic [W-1:0] w0, w1;
      int c, r;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_instr", instruction_out, 0);
      chk("rst_ready", load_ready, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_done", load_done, 0);
      chk("rst_error", load_error, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("run_hold", cpu_hold, 0);

      // Known two-word frame
      wq = '{12'h1A5, 12'h0F3};
      do_load(2, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("known_error", load_error, 0);
      fetch(0);
      fetch(1);

      // Full-depth frame (count equals 2^P)
      fill_words(DEPTH);
      do_load(DEPTH, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0);
      for (int i = 0; i < 6; i++) fetch($urandom_range(0, DEPTH - 1));
      fetch(DEPTH - 1);

      // Oversized counts: 65 and 0 (=256); memory untouched
      do_load(65, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("oversize_error", load_error, 1);
      fetch(0);
      fetch(DEPTH - 1);
      do_load(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      fetch(3);

      // Paced load with toggling valid and a long gap
      fill_words(10);
      do_load(10, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0);
      for (int i = 0; i < 10; i++) fetch(i);

      // Read alongside load_start, plus an ignored second load_start
      fill_words(8);
      do_load(8, 1'b1, 1'b0, 0, 1'b1, 5, 1'b1);
      fetch(5);
      fetch(7);

      // Corrupted checksum (only meaningful with the checksum option)
      fill_words(4);
      do_load(4, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0);
      fetch(2);
      fetch(3);

      // Reset part-way through a frame
      fill_words(2);
      w0 = wq[0];
      w1 = wq[1];
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      send_byte(8'h02, 1'b0);
      send_byte({4'h0, w0[W-1:8]}, 1'b0);
      send_byte(w0[7:0], 1'b0);
      send_byte({4'h0, w1[W-1:8]}, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_hold", cpu_hold, 0);
      chk("abort_ready", load_ready, 0);
      chk("abort_instr", instruction_out, 0);
      chk("abort_done", load_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ref_mem[0] = w0;
      wq.delete();
      fetch(0);
      fetch(1);

      // Randomised frames
      for (int it = 0; it < 6; it++) begin
         r = $urandom_range(0, 4);
         if (r == 0) c = $urandom_range(65, 256) % 256;
         else        c = $urandom_range(1, DEPTH);
         if (c != 0 && c <= DEPTH) fill_words(c);
         do_load(c, 1'b1, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b0, 0, 1'b0);
         for (int i = 0; i < 5; i++) fetch($urandom_range(0, DEPTH - 1));
      end

      repeat (5) @(negedge clk);
      chk("fetch_q_drained", fetch_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
